// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer: radix-2 restoring divider, MUL_LAT-stage multiplier, HI:LO accumulate.
// Latency: DIV 33 stall cycles, MULT 1+MUL_LAT, MADD/MSUB 2+MUL_LAT; result registered in DONE.
// Backpressure: DONE holds (no commit) while stall_i is high; flushE cancels from any state.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alu_controlE,
    input  logic [31:0] src_aE,
    input  logic [31:0] src_bE,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flushE,
    input  logic        stall_i,
    output logic        muldiv_stallE,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_o
);

    localparam logic [5:0] ALU_SIGNED_MULT   = 6'h18;
    localparam logic [5:0] ALU_UNSIGNED_MULT = 6'h19;
    localparam logic [5:0] ALU_SIGNED_DIV    = 6'h1A;
    localparam logic [5:0] ALU_UNSIGNED_DIV  = 6'h1B;
    localparam logic [5:0] ALU_MADD_MULT     = 6'h1C;
    localparam logic [5:0] ALU_MADDU_MULT    = 6'h1D;
    localparam logic [5:0] ALU_MSUB_MULT     = 6'h1E;
    localparam logic [5:0] ALU_MSUBU_MULT    = 6'h1F;

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_ACC, S_DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        op_sgn, op_acc, op_sub;
    logic        neg_q, neg_r;
    logic [31:0] a_reg, b_reg;
    logic [63:0] rq;
    logic [63:0] acc_r;

    logic        code_vld, code_div, code_sgn, code_acc, code_sub;
    logic        start;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        code_vld = 1'b1;
        code_div = 1'b0;
        code_sgn = 1'b0;
        code_acc = 1'b0;
        code_sub = 1'b0;
        case (alu_controlE)
            ALU_SIGNED_DIV:    begin code_div = 1'b1; code_sgn = 1'b1; end
            ALU_UNSIGNED_DIV:  code_div = 1'b1;
            ALU_SIGNED_MULT:   code_sgn = 1'b1;
            ALU_UNSIGNED_MULT: code_sgn = 1'b0;
            ALU_MADD_MULT:     begin code_sgn = 1'b1; code_acc = 1'b1; end
            ALU_MADDU_MULT:    code_acc = 1'b1;
            ALU_MSUB_MULT:     begin code_sgn = 1'b1; code_acc = 1'b1; code_sub = 1'b1; end
            ALU_MSUBU_MULT:    begin code_acc = 1'b1; code_sub = 1'b1; end
            default:           code_vld = 1'b0;
        endcase
    end

    assign start = (state == S_IDLE) && code_vld && !flushE;
    assign a_mag = (code_sgn && src_aE[31]) ? -src_aE : src_aE;
    assign b_mag = (code_sgn && src_bE[31]) ? -src_bE : src_bE;

    // One restoring step: shift, 33-bit trial subtract, keep on non-negative
    logic [63:0] rq_sh, rq_step;
    logic [32:0] trial;
    logic [31:0] quo, rem;
    logic [63:0] div_res;

    assign rq_sh   = {rq[62:0], 1'b0};
    assign trial   = {1'b0, rq_sh[63:32]} - {1'b0, b_reg};
    assign rq_step = trial[32] ? rq_sh : {trial[31:0], rq_sh[31:1], 1'b1};
    assign quo     = rq_step[31:0];
    assign rem     = rq_step[63:32];
    assign div_res = (b_reg == 32'd0) ? {a_reg, 32'hFFFF_FFFF}
                                      : {neg_r ? -rem : rem, neg_q ? -quo : quo};

    // 33-bit sign/zero extension; the low 64 bits of a 64x64 product are exact
    logic [63:0] a64, b64, mul_comb, mul_tap, acc_res;
    logic [63:0] mul_pipe [MUL_LAT];
    logic        mul_last;

    assign a64      = {{32{op_sgn & a_reg[31]}}, a_reg};
    assign b64      = {{32{op_sgn & b_reg[31]}}, b_reg};
    assign mul_comb = a64 * b64;
    assign mul_last = (cnt == 5'(MUL_LAT - 1));

    always_ff @(posedge clk) begin
        mul_pipe[0] <= mul_comb;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    // hilo_o acts as the last multiplier stage, so tap one stage early
    generate
        if (MUL_LAT == 1) begin : g_tap_comb
            assign mul_tap = mul_comb;
        end else begin : g_tap_pipe
            assign mul_tap = mul_pipe[MUL_LAT-2];
        end
    endgenerate

    assign acc_res = op_sub ? (acc_r - mul_pipe[MUL_LAT-1]) : (acc_r + mul_pipe[MUL_LAT-1]);

    always_comb begin
        state_nx      = state;
        muldiv_stallE = 1'b0;
        hilo_we       = 1'b0;
        case (state)
            S_IDLE: begin
                if (code_vld) begin
                    muldiv_stallE = 1'b1;
                    state_nx      = code_div ? S_DIV : S_MUL;
                end
            end
            S_DIV: begin
                muldiv_stallE = 1'b1;
                if (cnt == 5'd31) state_nx = S_DONE;
            end
            S_MUL: begin
                muldiv_stallE = 1'b1;
                if (mul_last) state_nx = op_acc ? S_ACC : S_DONE;
            end
            S_ACC: begin
                muldiv_stallE = 1'b1;
                state_nx      = S_DONE;
            end
            S_DONE: begin
                hilo_we = !stall_i;
                if (!stall_i) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (flushE) begin
            state_nx      = S_IDLE;
            muldiv_stallE = 1'b0;
            hilo_we       = 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            hilo_o <= 64'd0;
            op_sgn <= 1'b0;
            op_acc <= 1'b0;
            op_sub <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            rq     <= 64'd0;
            acc_r  <= 64'd0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt    <= 5'd0;
                op_sgn <= code_sgn;
                op_acc <= code_acc;
                op_sub <= code_sub;
                neg_q  <= code_sgn & (src_aE[31] ^ src_bE[31]);
                neg_r  <= code_sgn & src_aE[31];
                a_reg  <= src_aE;
                b_reg  <= code_div ? b_mag : src_bE;
                rq     <= {32'd0, a_mag};
                acc_r  <= {hi_i, lo_i};
            end else if (!flushE && (state == S_DIV || state == S_MUL)) begin
                cnt <= cnt + 5'd1;
                if (state == S_DIV) rq <= rq_step;
            end
            if (!flushE) begin
                if (state == S_DIV && cnt == 5'd31)
                    hilo_o <= div_res;
                else if (state == S_MUL && mul_last && !op_acc)
                    hilo_o <= mul_tap;
                else if (state == S_ACC)
                    hilo_o <= acc_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, HI:LO results, flush, downstream stall and reset.
module tb_muldiv_ctrl;

    localparam int LAT = 2;
    localparam logic [5:0] NOP   = 6'h00;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam logic [5:0] MADD  = 6'h1C;
    localparam logic [5:0] MSUBU = 6'h1F;

    logic        clk, rst, flushE, stall_i;
    logic [5:0]  alu_controlE;
    logic [31:0] src_aE, src_bE, hi_i, lo_i;
    logic        muldiv_stallE, busy, hilo_we;
    logic [63:0] hilo_o;

    int checks   = 0;
    int failures = 0;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .alu_controlE(alu_controlE),
        .src_aE(src_aE), .src_bE(src_bE), .hi_i(hi_i), .lo_i(lo_i),
        .flushE(flushE), .stall_i(stall_i),
        .muldiv_stallE(muldiv_stallE), .busy(busy), .hilo_we(hilo_we), .hilo_o(hilo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op at posedge+1 and runs until the first unstalled cycle (DONE);
    // returns at posedge+1 of the following cycle with a NOP in E.
    task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l,
                          output int n_stall, output int n_we, output logic [63:0] res);
        alu_controlE = code; src_aE = a; src_bE = b; hi_i = h; lo_i = l;
        n_stall = 0; n_we = 0; res = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #2;
            if (hilo_we) n_we++;
            if (!muldiv_stallE) begin
                res = hilo_o;
                @(posedge clk); #1;
                alu_controlE = NOP;
                #2;
                if (hilo_we) n_we++;
                return;
            end
            n_stall++;
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL run_op_timeout code=%h still stalled after 200 cycles", code);
        alu_controlE = NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (muldiv_stallE !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", muldiv_stallE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (hilo_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", hilo_we); end
        checks++; if (hilo_o !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", hilo_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ignored();
        alu_controlE = NOP; #2;
        checks++; if (muldiv_stallE !== 1'b0) begin failures++; $display("FAIL ignored_nop_stall got=%b exp=0", muldiv_stallE); end
        @(posedge clk); #1;
        alu_controlE = 6'h20; #2;
        checks++; if (muldiv_stallE !== 1'b0) begin failures++; $display("FAIL ignored_code_stall got=%b exp=0", muldiv_stallE); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_code_busy got=%b exp=0", busy); end
        alu_controlE = DIVU; flushE = 1'b1; #2;
        checks++; if (muldiv_stallE !== 1'b0) begin failures++; $display("FAIL flushed_start_stall got=%b exp=0", muldiv_stallE); end
        @(posedge clk); #1;
        flushE = 1'b0; alu_controlE = NOP;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flushed_start_busy got=%b exp=0", busy); end
    endtask

    task automatic test_div();
        int ns, nw;
        logic [63:0] r;
        run_op(DIVU, 32'd100, 32'd7, 32'd0, 32'd0, ns, nw, r);
        checks++; if (ns !== 33) begin failures++; $display("FAIL divu_stall got=%0d exp=33", ns); end
        checks++; if (nw !== 1) begin failures++; $display("FAIL divu_we_pulses got=%0d exp=1", nw); end
        checks++; if (r !== 64'h0000_0002_0000_000E) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", r, 64'h0000_0002_0000_000E); end
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFD); end
        checks++; if (ns !== 33) begin failures++; $display("FAIL div_stall got=%0d exp=33", ns); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_overflow got=%h exp=%h", r, 64'h0000_0000_8000_0000); end
        run_op(DIVU, 32'd9, 32'd0, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'h0000_0009_FFFF_FFFF) begin failures++; $display("FAIL divu_by_zero got=%h exp=%h", r, 64'h0000_0009_FFFF_FFFF); end
        checks++; if (ns !== 33) begin failures++; $display("FAIL divu_by_zero_stall got=%0d exp=33", ns); end
        run_op(DIV, 32'hFFFF_FFF7, 32'd0, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'hFFFF_FFF7_FFFF_FFFF) begin failures++; $display("FAIL div_by_zero got=%h exp=%h", r, 64'hFFFF_FFF7_FFFF_FFFF); end
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'h0000_0001_FFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h exp=%h", r, 64'h0000_0001_FFFF_FFFD); end
    endtask

    task automatic test_mul();
        int ns, nw;
        logic [63:0] r;
        run_op(MULT, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mult got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFFE); end
        checks++; if (ns !== 1 + LAT) begin failures++; $display("FAIL mult_stall got=%0d exp=%0d", ns, 1 + LAT); end
        checks++; if (nw !== 1) begin failures++; $display("FAIL mult_we_pulses got=%0d exp=1", nw); end
        run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'h0000_0001_FFFF_FFFE) begin failures++; $display("FAIL multu got=%h exp=%h", r, 64'h0000_0001_FFFF_FFFE); end
        checks++; if (ns !== 1 + LAT) begin failures++; $display("FAIL multu_stall got=%0d exp=%0d", ns, 1 + LAT); end
    endtask

    task automatic test_acc();
        int ns, nw;
        logic [63:0] r;
        run_op(MADD, 32'd3, 32'd4, 32'd0, 32'd5, ns, nw, r);
        checks++; if (r !== 64'd17) begin failures++; $display("FAIL madd got=%h exp=%h", r, 64'd17); end
        checks++; if (ns !== 2 + LAT) begin failures++; $display("FAIL madd_stall got=%0d exp=%0d", ns, 2 + LAT); end
        run_op(MSUBU, 32'd3, 32'd4, 32'd0, 32'd5, ns, nw, r);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF9) begin failures++; $display("FAIL msubu got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFF9); end
        checks++; if (ns !== 2 + LAT) begin failures++; $display("FAIL msubu_stall got=%0d exp=%0d", ns, 2 + LAT); end
        checks++; if (nw !== 1) begin failures++; $display("FAIL msubu_we_pulses got=%0d exp=1", nw); end
    endtask

    // Flush at DIV iteration 10, then a MULTU with no dead cycle
    task automatic test_flush_back_to_back();
        int ns, nw;
        logic [63:0] r;
        logic [63:0] prev;
        prev = 64'hFFFF_FFFF_FFFF_FFF9;
        alu_controlE = DIVU; src_aE = 32'd100; src_bE = 32'd7;
        repeat (11) begin @(posedge clk); #1; end
        flushE = 1'b1; #2;
        checks++; if (muldiv_stallE !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", muldiv_stallE); end
        checks++; if (hilo_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", hilo_we); end
        @(posedge clk); #1;
        flushE = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
        checks++; if (hilo_o !== prev) begin failures++; $display("FAIL flush_hilo_kept got=%h exp=%h", hilo_o, prev); end
        run_op(MULTU, 32'd3, 32'd5, 32'd0, 32'd0, ns, nw, r);
        checks++; if (r !== 64'd15) begin failures++; $display("FAIL after_flush_multu got=%h exp=%h", r, 64'd15); end
        checks++; if (ns !== 1 + LAT) begin failures++; $display("FAIL after_flush_stall got=%0d exp=%0d", ns, 1 + LAT); end
        checks++; if (nw !== 1) begin failures++; $display("FAIL after_flush_we got=%0d exp=1", nw); end
    endtask

    task automatic test_stall_i();
        int ns;
        ns = 0;
        stall_i = 1'b1;
        alu_controlE = MULTU; src_aE = 32'd6; src_bE = 32'd7;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #2;
            if (!muldiv_stallE) break;
            ns++;
            @(posedge clk); #1;
        end
        checks++; if (ns !== 1 + LAT) begin failures++; $display("FAIL hold_stall got=%0d exp=%0d", ns, 1 + LAT); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (hilo_we !== 1'b0) begin failures++; $display("FAIL hold_we cyc=%0d got=%b exp=0", k, hilo_we); end
            checks++; if (hilo_o !== 64'd42) begin failures++; $display("FAIL hold_hilo cyc=%0d got=%h exp=%h", k, hilo_o, 64'd42); end
            checks++; if (busy !== 1'b1 || muldiv_stallE !== 1'b0) begin failures++; $display("FAIL hold_state cyc=%0d busy=%b stall=%b exp busy=1 stall=0", k, busy, muldiv_stallE); end
            @(posedge clk); #1;
        end
        stall_i = 1'b0; #2;
        checks++; if (hilo_we !== 1'b1) begin failures++; $display("FAIL release_we got=%b exp=1", hilo_we); end
        checks++; if (hilo_o !== 64'd42) begin failures++; $display("FAIL release_hilo got=%h exp=%h", hilo_o, 64'd42); end
        @(posedge clk); #1;
        alu_controlE = NOP; #2;
        checks++; if (busy !== 1'b0 || hilo_we !== 1'b0) begin failures++; $display("FAIL release_idle busy=%b we=%b exp 0 0", busy, hilo_we); end
    endtask

    task automatic test_reset_mid_div();
        int nw;
        nw = 0;
        alu_controlE = DIVU; src_aE = 32'd1000; src_bE = 32'd3;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_div_busy got=%b exp=1", busy); end
        rst = 1'b1; alu_controlE = NOP;
        #2; if (hilo_we) nw++;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (muldiv_stallE !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", muldiv_stallE); end
        checks++; if (hilo_o !== 64'd0) begin failures++; $display("FAIL mid_rst_hilo got=%h exp=0", hilo_o); end
        if (hilo_we) nw++;
        checks++; if (nw !== 0) begin failures++; $display("FAIL mid_rst_commit got=%0d exp=0", nw); end
    endtask

    initial begin
        rst = 1'b1; flushE = 1'b0; stall_i = 1'b0;
        alu_controlE = NOP; src_aE = '0; src_bE = '0; hi_i = '0; lo_i = '0;
        test_reset();
        test_ignored();
        test_div();
        test_mul();
        test_acc();
        test_flush_back_to_back();
        test_stall_i();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
